aes_key_expand: RTL and testbench



---
 rtl/aes_key_expand.sv | 165 ++++++++++++++++
 tb/tb_aes_key_expand.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// aes_key_expand: sequential AES key schedule that writes one 128-bit round key per cycle into a readable memory.
// Define AES_KEY256_EN to honour keylen and add the 256-bit schedule (15-entry memory); otherwise AES-128 only.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (8'h1b & {8{xx[7]}});
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x12, x15, x240, inv;

    // Multiplicative inverse as a^254 in GF(2^8), then the S-box affine map.
    always_comb begin
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic         init,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready
);
`ifdef AES_KEY256_EN
    localparam int NUM_KEYS = 15;
`else
    localparam int NUM_KEYS = 11;
`endif

    // IDLE: wait for init | INIT: load raw key words | GENERATE: one round key per cycle
    typedef enum logic [1:0] {IDLE, INIT, GENERATE} state_t;

    state_t       state;
    logic [127:0] mem [NUM_KEYS];
    logic [127:0] key_hi;
    logic [127:0] prev_key1;
    logic [7:0]   rcon;
    logic [3:0]   round_ctr;
`ifdef AES_KEY256_EN
    logic [127:0] key_lo;
    logic [127:0] prev_key0;
    logic         aes256;
`else
    logic         unused_inputs;
    assign unused_inputs = ^{key[127:0], keylen};
`endif

    logic [3:0]   last_idx;
    logic         odd_step;
    logic [31:0]  sub_in, sub_out, t;
    logic [127:0] base, next_key;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .s(sub_out[8*b +: 8]));
    end

    always_comb begin
        base     = prev_key1;
        sub_in   = {prev_key1[23:0], prev_key1[31:24]};
        odd_step = 1'b0;
        last_idx = 4'd10;
`ifdef AES_KEY256_EN
        if (aes256) begin
            base     = prev_key0;
            last_idx = 4'd14;
            odd_step = round_ctr[0];
            if (round_ctr[0]) sub_in = prev_key1[31:0];
        end
`endif
        t = odd_step ? sub_out : (sub_out ^ {rcon, 24'h0});
        next_key[127:96] = base[127:96] ^ t;
        next_key[95:64]  = base[95:64]  ^ next_key[127:96];
        next_key[63:32]  = base[63:32]  ^ next_key[95:64];
        next_key[31:0]   = base[31:0]   ^ next_key[63:32];
    end

    always_comb begin
        round_key = '0;
        if (round <= last_idx) round_key = mem[round];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b0;
            key_hi    <= '0;
            prev_key1 <= '0;
            rcon      <= '0;
            round_ctr <= '0;
            for (int i = 0; i < NUM_KEYS; i++) mem[i] <= '0;
`ifdef AES_KEY256_EN
            key_lo    <= '0;
            prev_key0 <= '0;
            aes256    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (init) begin
                        key_hi <= key[255:128];
`ifdef AES_KEY256_EN
                        key_lo <= key[127:0];
                        aes256 <= keylen;
`endif
                        ready  <= 1'b0;
                        state  <= INIT;
                    end
                end
                INIT: begin
                    mem[0]    <= key_hi;
                    prev_key1 <= key_hi;
                    rcon      <= 8'h01;
                    round_ctr <= 4'd1;
`ifdef AES_KEY256_EN
                    if (aes256) begin
                        mem[1]    <= key_lo;
                        prev_key0 <= key_hi;
                        prev_key1 <= key_lo;
                        round_ctr <= 4'd2;
                    end
`endif
                    state <= GENERATE;
                end
                GENERATE: begin
                    mem[round_ctr] <= next_key;
                    prev_key1      <= next_key;
`ifdef AES_KEY256_EN
                    prev_key0      <= prev_key1;
`endif
                    if (!odd_step) rcon <= {rcon[6:0], 1'b0} ^ (8'h1b & {8{rcon[7]}});
                    round_ctr <= round_ctr + 4'd1;
                    if (round_ctr == last_idx) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key-schedule vectors.
// The AES-256 scenario is exercised when AES_KEY256_EN is defined; otherwise keylen must be ignored.

module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] key = '0;
    logic         keylen = 1'b0;
    logic         init = 1'b0;
    logic [3:0]   round = '0;
    logic [127:0] round_key;
    logic         ready;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [255:0] K_FIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K_SEQ  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K_256  = {128'h000102030405060708090a0b0c0d0e0f,
                                       128'h101112131415161718191a1b1c1d1e1f};

    aes_key_expand dut (
        .clk(clk), .reset(reset), .key(key), .keylen(keylen),
        .init(init), .round(round), .round_key(round_key), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic read_key(input logic [3:0] r, output logic [127:0] v);
        round = r;
        #1;
        v = round_key;
    endtask

    // Pulses init for one cycle; returns with time just after the accepting edge E0.
    task automatic start(input logic [255:0] k, input logic kl);
        @(posedge clk); #1;
        key = k; keylen = kl; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ready) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [127:0] v;
        for (int r = 0; r < 16; r++) begin
            read_key(4'(r), v);
            n_cmp++;
            if (v !== '0) begin
                n_err++;
                $display("FAIL reset_round_key[%0d]: got %h expected 0", r, v);
            end
        end
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        read_key(4'd0, v);
        n_cmp++;
        if (ready !== 1'b0 || v !== '0) begin
            n_err++;
            $display("FAIL idle_after_reset: ready %b key %h expected 0/0", ready, v);
        end
    endtask

    task automatic test_aes128_fips;
        int cyc;
        logic [127:0] v;
        start(K_FIPS, 1'b0);
        wait_ready(cyc);
        n_cmp++;
        if (cyc != 11) begin n_err++; $display("FAIL fips_latency: got %0d expected 11", cyc); end
        read_key(4'd0, v);
        n_cmp++;
        if (v !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin n_err++; $display("FAIL fips_r0: got %h", v); end
        read_key(4'd1, v);
        n_cmp++;
        if (v !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_err++; $display("FAIL fips_r1: got %h", v); end
        read_key(4'd2, v);
        n_cmp++;
        if (v !== 128'hf2c295f27a96b9435935807a7359f67f) begin n_err++; $display("FAIL fips_r2: got %h", v); end
        read_key(4'd10, v);
        n_cmp++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_err++; $display("FAIL fips_r10: got %h", v); end
    endtask

    task automatic test_out_of_range;
        logic [127:0] v;
        for (int r = 11; r < 16; r++) begin
            read_key(4'(r), v);
            n_cmp++;
            if (v !== '0) begin n_err++; $display("FAIL oor_round[%0d]: got %h expected 0", r, v); end
        end
    endtask

    task automatic test_aes128_seq;
        int cyc;
        logic [127:0] v;
        start(K_SEQ, 1'b0);
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL reinit_ready_drop: got %b expected 0", ready); end
        wait_ready(cyc);
        n_cmp++;
        if (cyc != 11) begin n_err++; $display("FAIL seq_latency: got %0d expected 11", cyc); end
        read_key(4'd1, v);
        n_cmp++;
        if (v !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe) begin n_err++; $display("FAIL seq_r1: got %h", v); end
        read_key(4'd10, v);
        n_cmp++;
        if (v !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin n_err++; $display("FAIL seq_r10: got %h", v); end
    endtask

    task automatic test_keylen;
        int cyc;
        logic [127:0] v;
        start(K_256, 1'b1);
        wait_ready(cyc);
`ifdef AES_KEY256_EN
        n_cmp++;
        if (cyc != 14) begin n_err++; $display("FAIL k256_latency: got %0d expected 14", cyc); end
        read_key(4'd1, v);
        n_cmp++;
        if (v !== 128'h101112131415161718191a1b1c1d1e1f) begin n_err++; $display("FAIL k256_r1: got %h", v); end
        read_key(4'd2, v);
        n_cmp++;
        if (v !== 128'ha573c29fa176c498a97fce93a572c09c) begin n_err++; $display("FAIL k256_r2: got %h", v); end
        read_key(4'd14, v);
        n_cmp++;
        if (v !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin n_err++; $display("FAIL k256_r14: got %h", v); end
        read_key(4'd15, v);
        n_cmp++;
        if (v !== '0) begin n_err++; $display("FAIL k256_r15: got %h expected 0", v); end
`else
        n_cmp++;
        if (cyc != 11) begin n_err++; $display("FAIL keylen_ignored_latency: got %0d expected 11", cyc); end
        read_key(4'd10, v);
        n_cmp++;
        if (v !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin n_err++; $display("FAIL keylen_ignored_r10: got %h", v); end
        read_key(4'd11, v);
        n_cmp++;
        if (v !== '0) begin n_err++; $display("FAIL keylen_ignored_r11: got %h expected 0", v); end
`endif
    endtask

    task automatic test_init_ignored;
        int cyc;
        logic [127:0] v;
        start(K_FIPS, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        key = K_SEQ; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        wait_ready(cyc);
        n_cmp++;
        if (cyc != 7) begin n_err++; $display("FAIL ignored_latency: got %0d expected 7", cyc); end
        read_key(4'd1, v);
        n_cmp++;
        if (v !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_err++; $display("FAIL ignored_r1: got %h", v); end
        read_key(4'd10, v);
        n_cmp++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_err++; $display("FAIL ignored_r10: got %h", v); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL ignored_no_restart: ready %b expected 1", ready); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        logic [127:0] v;
        start(K_SEQ, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        read_key(4'd0, v);
        n_cmp++;
        if (ready !== 1'b0 || v !== '0) begin
            n_err++;
            $display("FAIL midreset_r0: ready %b key %h expected 0/0", ready, v);
        end
        read_key(4'd10, v);
        n_cmp++;
        if (v !== '0) begin n_err++; $display("FAIL midreset_r10: got %h expected 0", v); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL midreset_stays_idle: ready %b expected 0", ready); end
        start(K_FIPS, 1'b0);
        wait_ready(cyc);
        n_cmp++;
        if (cyc != 11) begin n_err++; $display("FAIL reinit_latency: got %0d expected 11", cyc); end
        read_key(4'd10, v);
        n_cmp++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_err++; $display("FAIL reinit_r10: got %h", v); end
    endtask

    initial begin
        test_reset;
        test_aes128_fips;
        test_out_of_range;
        test_aes128_seq;
        test_keylen;
        test_init_ignored;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
